// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with accumulate mode.
// Valid/ready in and out; a stall freezes every stage.
module ks_pipe_adder #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LVLS = $clog2(WIDTH);

  typedef struct packed {
    logic             v;
    logic             ac;
    logic             c0;
    logic [WIDTH-1:0] hs;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } stg_t;

  logic             adv;
  logic             in_fire;
  logic             out_fire;
  logic             busy;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] px;
  logic [WIDTH-1:0] py;
  logic             pc;
  stg_t             s0_in;
  stg_t             st0;
  stg_t             cur [0:LVLS];
  stg_t             o;

  assign adv      = ena & ~(out_valid & ~out_ready);
  assign in_ready = adv & ~busy;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ena;

  // Operand prep; carry-in is folded into the bit-0 generate.
  always_comb begin
    px = '0;
    py = '0;
    pc = 1'b0;
    unique case (1'b1)
      (mode == 2'b00): begin
        px = a;
        py = b;
        pc = cin;
      end
      (mode == 2'b01): begin
        px = a;
        py = ~b;
        pc = 1'b1;
      end
      (mode == 2'b10): begin
        px = acc;
        py = b;
        pc = cin;
      end
      (mode == 2'b11): begin
        px = '0;
        py = '0;
        pc = 1'b0;
      end
      default: begin
        px = '0;
        py = '0;
        pc = 1'b0;
      end
    endcase
    s0_in      = '0;
    s0_in.v    = 1'b1;
    s0_in.ac   = (mode == 2'b10);
    s0_in.c0   = pc;
    s0_in.hs   = px ^ py;
    s0_in.p    = px ^ py;
    s0_in.g    = px & py;
    s0_in.g[0] = (px[0] & py[0]) | ((px[0] ^ py[0]) & pc);
  end

  // Stage 0: capture operands on input transfer only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0 <= '0;
    end else if (adv) begin
      if (in_fire) begin
        st0 <= s0_in;
      end else begin
        st0.v <= 1'b0;
      end
    end
  end

  assign cur[0] = st0;

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    localparam int D = 1 << k;
    stg_t nx;

    // Prefix level at distance D.
    always_comb begin
      nx = cur[k];
      for (int i = D; i < WIDTH; i++) begin
        nx.g[i] = cur[k].g[i]
                | (cur[k].p[i] & cur[k].g[i-D]);
        nx.p[i] = cur[k].p[i] & cur[k].p[i-D];
      end
    end

    if (PIPE != 0) begin : g_reg
      stg_t r;

      // Level register; data held across bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r <= '0;
        end else if (adv) begin
          if (cur[k].v) begin
            r <= nx;
          end else begin
            r.v <= 1'b0;
          end
        end
      end

      assign cur[k+1] = r;
    end else begin : g_cmb
      assign cur[k+1] = nx;
    end
  end

  assign o         = cur[LVLS];
  assign out_valid = o.v;
  assign sum       = o.hs ^ {o.g[WIDTH-2:0], o.c0};
  assign cout      = o.g[WIDTH-1];
  assign ovf       = o.g[WIDTH-1] ^ o.g[WIDTH-2];

  // Accumulator and the accumulate-in-flight hazard flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      busy <= 1'b0;
    end else begin
      if (in_fire && mode == 2'b11) begin
        acc <= '0;
      end
      if (out_fire && o.ac) begin
        acc <= sum;
      end
      if (in_fire && mode == 2'b10) begin
        busy <= 1'b1;
      end else if (out_fire && o.ac) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Scoreboard bench for ks_pipe_adder.
// Two instances: WIDTH=8/PIPE=1 and WIDTH=16/PIPE=0.
module tb_ks_pipe_adder;

  typedef struct {
    logic [33:0] e;
    int          t;
    logic        ac;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;

  logic        v8, r8, ov8, or8, ci8, co8, of8;
  logic [1:0]  m8;
  logic [7:0]  a8, b8, s8;
  logic        v16, r16, ov16, or16, ci16, co16, of16;
  logic [1:0]  m16;
  logic [15:0] a16, b16, s16;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  sb_t         q8[$];
  sb_t         q16[$];
  sb_t         it8, it16;
  logic [33:0] ex8, ex16;
  logic [7:0]  macc8;
  logic        pend8;
  logic        lat8, lat16;
  logic        rnd8, frc8;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    or8 = rnd8 ? 1'($urandom_range(0, 1)) : frc8;
  end

  ks_pipe_adder #(.WIDTH(8), .PIPE(1)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(v8), .in_ready(r8),
    .mode(m8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(co8), .ovf(of8)
  );

  ks_pipe_adder #(.WIDTH(16), .PIPE(0)) u16 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(v16), .in_ready(r16),
    .mode(m16), .a(a16), .b(b16), .cin(ci16),
    .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .ovf(of16)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mdl(
    input int w, input logic [1:0] m,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] acc, input logic ci);
    logic [31:0] msk, x, y, s;
    logic [32:0] f;
    logic        c, co, ov;
    msk = (w == 32) ? '1 : ((32'h1 << w) - 32'h1);
    x = '0; y = '0; c = 1'b0;
    case (m)
      2'd0: begin x = a & msk; y = b & msk; c = ci; end
      2'd1: begin x = a & msk; y = ~b & msk; c = 1'b1; end
      2'd2: begin x = acc & msk; y = b & msk; c = ci; end
      default: begin x = '0; y = '0; c = 1'b0; end
    endcase
    f  = {1'b0, x} + {1'b0, y} + {32'h0, c};
    s  = f[31:0] & msk;
    co = f[w];
    ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (pend8) chk("acc_busy8", 64'(r8), 64'd0);
      if (ov8 && or8 && ena) begin
        if (q8.size() == 0) begin
          chk("extra8", 64'd1, 64'd0);
        end else begin
          it8 = q8.pop_front();
          chk("res8", 64'({of8, co8, s8}),
              64'({it8.e[33:32], it8.e[7:0]}));
          if (lat8) chk("lat8", 64'(cyc - it8.t + 1), 64'd4);
          if (it8.ac) pend8 = 1'b0;
        end
      end
      if (v8 && r8) begin
        ex8 = mdl(8, m8, {24'h0, a8}, {24'h0, b8},
                  {24'h0, macc8}, ci8);
        if (m8 == 2'd2) macc8 = ex8[7:0];
        if (m8 == 2'd3) macc8 = 8'h0;
        q8.push_back('{e: ex8, t: cyc + 1, ac: (m8 == 2'd2)});
        if (m8 == 2'd2) pend8 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov16 && or16 && ena) begin
        if (q16.size() == 0) begin
          chk("extra16", 64'd1, 64'd0);
        end else begin
          it16 = q16.pop_front();
          chk("res16", 64'({of16, co16, s16}),
              64'({it16.e[33:32], it16.e[15:0]}));
          if (lat16) chk("lat16", 64'(cyc - it16.t + 1), 64'd1);
        end
      end
      if (v16 && r16) begin
        ex16 = mdl(16, m16, {16'h0, a16}, {16'h0, b16},
                   32'h0, ci16);
        q16.push_back('{e: ex16, t: cyc + 1, ac: 1'b0});
      end
    end
  end

  task automatic send8(input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic ci);
    int n = 0;
    v8 = 1'b1; m8 = m; a8 = a; b8 = b; ci8 = ci;
    do begin
      @(negedge clk);
      n++;
    end while (!r8 && n < 200);
    if (!r8) chk("send8_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] b, input logic ci);
    int n = 0;
    v16 = 1'b1; m16 = m; a16 = a; b16 = b; ci16 = ci;
    do begin
      @(negedge clk);
      n++;
    end while (!r16 && n < 200);
    if (!r16) chk("send16_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain8();
    int n = 0;
    v8 = 1'b0;
    while (q8.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", 64'(q8.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain16();
    int n = 0;
    v16 = 1'b0;
    while (q16.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain16", 64'(q16.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [33:0] hx;
    rst_n = 1'b0; ena = 1'b1;
    v8 = 0; m8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    v16 = 0; m16 = 0; a16 = 0; b16 = 0; ci16 = 0; or16 = 1'b1;
    macc8 = 0; pend8 = 0; lat8 = 0; lat16 = 0;
    rnd8 = 0; frc8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov8", 64'(ov8), 64'd0);
    chk("rst_out8", 64'({of8, co8, s8}), 64'd0);
    chk("rst_ov16", 64'(ov16), 64'd0);
    chk("rst_out16", 64'({of16, co16, s16}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 64'({r8, r16}), 64'd3);
    @(posedge clk);
    #1;

    lat8 = 1'b1;
    send8(2'd0, 8'hFF, 8'h01, 1'b0);
    drain8();
    send8(2'd0, 8'h7F, 8'h01, 1'b0);
    drain8();
    lat8 = 1'b0;
    chk("add_7f_sum", 64'({of8, s8}), 64'h180);

    send8(2'd1, 8'h05, 8'h07, 1'b0);
    send8(2'd1, 8'h80, 8'h01, 1'b0);
    drain8();
    chk("sub_80_flags", 64'({of8, co8, s8}), 64'h37F);

    rnd8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send8(2'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom), 1'($urandom_range(0, 1)));
    end
    drain8();
    rnd8 = 1'b0;

    send8(2'd3, 8'hAA, 8'h55, 1'b1);
    send8(2'd2, 8'h00, 8'h10, 1'b0);
    send8(2'd2, 8'h00, 8'h20, 1'b0);
    send8(2'd2, 8'h00, 8'h30, 1'b0);
    drain8();
    chk("acc_60", 64'(s8), 64'h60);
    send8(2'd0, 8'h01, 8'h01, 1'b0);
    send8(2'd2, 8'hFF, 8'h00, 1'b0);
    drain8();
    chk("acc_kept", 64'(s8), 64'h60);

    send8(2'd0, 8'h01, 8'h02, 1'b0);
    send8(2'd0, 8'h03, 8'h04, 1'b0);
    send8(2'd0, 8'h05, 8'h06, 1'b0);
    v8 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ov", 64'(ov8), 64'd0);
    chk("rst_async_sum", 64'(s8), 64'd0);
    q8.delete();
    pend8 = 1'b0;
    macc8 = 8'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_rst", 64'(r8), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stale", 64'(ov8), 64'd0);
    end
    @(posedge clk);
    #1;
    send8(2'd2, 8'h00, 8'h05, 1'b0);
    drain8();
    chk("acc_rst", 64'(s8), 64'h05);

    lat16 = 1'b1;
    send16(2'd0, 16'hFFFF, 16'h0000, 1'b1);
    drain16();
    lat16 = 1'b0;
    chk("w16_wrap", 64'({co16, s16}), 64'h10000);

    send16(2'd0, 16'h1234, 16'h1111, 1'b0);
    send16(2'd1, 16'h0100, 16'h0001, 1'b0);
    v16 = 1'b0;
    ena = 1'b0;
    or16 = 1'b0;
    hx = mdl(16, 2'd1, 32'h0100, 32'h0001, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("frz_ov", 64'(ov16), 64'd1);
      chk("frz_out", 64'({of16, co16, s16}),
          64'({hx[33:32], hx[15:0]}));
      chk("frz_rdy", 64'(r16), 64'd0);
    end
    @(posedge clk);
    #1;
    ena = 1'b1;
    or16 = 1'b1;
    send16(2'd0, 16'h8000, 16'h8000, 1'b0);
    send16(2'd1, 16'h0003, 16'h0005, 1'b0);
    drain16();

    chk("q8_empty", 64'(q8.size()), 64'd0);
    chk("q16_empty", 64'(q16.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
